// File: rtl/display_scan_ctrl.sv
// Button-driven display selector with debounced next/prev/mode inputs and an optional auto-scan mode.
// Define DISP_SCAN_AUTO_EN to compile in the AUTO state, dwell counter, hold and btn_mode handling.

module display_scan_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only survives while the synchronized input keeps disagreeing with the accepted level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  assign press = press_q;

endmodule

module display_scan_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_mode,
  input  logic       hold,
  output logic [3:0] sel,
  output logic       auto_active,
  output logic       step_pulse
);

  logic       next_press;
  logic       prev_press;
  logic       inc_req;
  logic       dec_req;
  logic       manual_step;
  logic       dwell_done;
  logic [3:0] sel_q, sel_d;
  logic       step_q, step_d;

  display_scan_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .press   (next_press)
  );

  display_scan_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_prev),
    .press   (prev_press)
  );

  // Simultaneous next and prev cancel each other out.
  assign inc_req     = next_press & ~prev_press;
  assign dec_req     = prev_press & ~next_press;
  assign manual_step = inc_req | dec_req;

`ifdef DISP_SCAN_AUTO_EN

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  logic            mode_press;
  state_t          state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;

  display_scan_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_mode),
    .press   (mode_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      state_d = (state_q == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
    end
  end

  always_comb begin
    auto_active = (state_q == ST_AUTO);
  end

  // Mode changes and manual steps restart the dwell; a manual step also pre-empts a terminal count.
  always_comb begin
    dwell_d    = '0;
    dwell_done = 1'b0;
    if ((state_q == ST_AUTO) && !mode_press && !manual_step) begin
      if (hold) begin
        dwell_d = dwell_q;
      end else if (dwell_q == DW_LAST) begin
        dwell_done = 1'b1;
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

`else

  logic unused_auto_inputs;

  assign unused_auto_inputs = btn_mode ^ hold;
  assign dwell_done         = 1'b0;
  assign auto_active        = 1'b0;

`endif

  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    if (inc_req) begin
      sel_d  = sel_q + 4'd1;
      step_d = 1'b1;
    end else if (dec_req) begin
      sel_d  = sel_q - 4'd1;
      step_d = 1'b1;
    end else if (dwell_done) begin
      sel_d  = sel_q + 4'd1;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 4'd0;
      step_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      step_q <= step_d;
    end
  end

  assign sel        = sel_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DEBOUNCE_CYCLES=4 and DWELL_CYCLES=8.
// Auto-mode scenarios run when DISP_SCAN_AUTO_EN is defined; otherwise the disabled-feature scenario runs.

module tb_display_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_mode;
  logic       hold;
  logic [3:0] sel;
  logic       auto_active;
  logic       step_pulse;

  int checks = 0;
  int errors = 0;
  int step_count = 0;
  int cyc = 0;
  int exp_sel = 0;

  display_scan_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DWELL_CYCLES    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .btn_mode    (btn_mode),
    .hold        (hold),
    .sel         (sel),
    .auto_active (auto_active),
    .step_pulse  (step_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with step_pulse high counts as one step, so stretched pulses show up as extra steps.
  always @(negedge clk) begin
    if (rst_n && step_pulse) step_count <= step_count + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_next = v;
      1: btn_prev = v;
      2: btn_mode = v;
      default: begin
        btn_next = v;
        btn_prev = v;
      end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input int hi, input int lo);
    set_btn(which, 1'b1);
    idle(hi);
    set_btn(which, 1'b0);
    idle(lo);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_mode = 1'b0;
    hold = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    exp_sel = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sel !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_sel: got %0d expected 0", sel);
    end
    checks++;
    if (auto_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_auto: got %0b expected 0", auto_active);
    end
    checks++;
    if (step_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_step: got %0b expected 0", step_pulse);
    end
  endtask

  task automatic test_single_press();
    int base;
    base = step_count;
    btn_next = 1'b1;
    idle(20);
    exp_sel = (exp_sel + 1) % 16;
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL held_sel: got %0d expected %0d", sel, exp_sel);
    end
    btn_next = 1'b0;
    idle(12);
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL released_sel: got %0d expected %0d", sel, exp_sel);
    end
    checks++;
    if (step_count - base !== 1) begin
      errors++;
      $display("[TB] FAIL single_press_pulses: got %0d expected 1", step_count - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = step_count;
    repeat (6) press(0, 3, 3);
    idle(10);
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL glitch_sel: got %0d expected %0d", sel, exp_sel);
    end
    checks++;
    if (step_count - base !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_pulses: got %0d expected 0", step_count - base);
    end
  endtask

  task automatic test_wrap();
    while (exp_sel != 15) begin
      press(1, 12, 12);
      exp_sel = (exp_sel + 15) % 16;
    end
    checks++;
    if (sel !== 4'd15) begin
      errors++;
      $display("[TB] FAIL wrap_setup: got %0d expected 15", sel);
    end
    press(0, 12, 12);
    exp_sel = (exp_sel + 1) % 16;
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL wrap_up: got %0d expected %0d", sel, exp_sel);
    end
    press(1, 12, 12);
    exp_sel = (exp_sel + 15) % 16;
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL wrap_down: got %0d expected %0d", sel, exp_sel);
    end
  endtask

  // Random mix of clean next/prev/both presses and sub-debounce glitches.
  task automatic test_random_manual();
    int base;
    int kind;
    int exp_steps;
    for (int i = 0; i < 12; i++) begin
      base = step_count;
      kind = int'($urandom_range(0, 3));
      exp_steps = 0;
      case (kind)
        0: begin
          press(0, int'($urandom_range(8, 20)), 12);
          exp_sel = (exp_sel + 1) % 16;
          exp_steps = 1;
        end
        1: begin
          press(1, int'($urandom_range(8, 20)), 12);
          exp_sel = (exp_sel + 15) % 16;
          exp_steps = 1;
        end
        2: press(3, int'($urandom_range(8, 20)), 12);
        default: press(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 12);
      endcase
      checks++;
      if (sel !== 4'(exp_sel)) begin
        errors++;
        $display("[TB] FAIL random_sel[%0d] kind %0d: got %0d expected %0d", i, kind, sel, exp_sel);
      end
      checks++;
      if (step_count - base !== exp_steps) begin
        errors++;
        $display("[TB] FAIL random_pulses[%0d] kind %0d: got %0d expected %0d", i, kind, step_count - base, exp_steps);
      end
    end
  endtask

  task automatic test_reset_held();
    int base;
    btn_next = 1'b1;
    idle(6);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_sel = 0;
    base = step_count;
    checks++;
    if (sel !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_held_sel0: got %0d expected 0", sel);
    end
    checks++;
    if (step_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held_step0: got %0b expected 0", step_pulse);
    end
    idle(20);
    btn_next = 1'b0;
    idle(12);
    exp_sel = 1;
    checks++;
    if (sel !== 4'(exp_sel)) begin
      errors++;
      $display("[TB] FAIL reset_held_sel: got %0d expected %0d", sel, exp_sel);
    end
    checks++;
    if (step_count - base !== 1) begin
      errors++;
      $display("[TB] FAIL reset_held_pulses: got %0d expected 1", step_count - base);
    end
  endtask

`ifdef DISP_SCAN_AUTO_EN

  task automatic test_auto_dwell();
    int base;
    int t_entry;
    int t1;
    int t2;
    int t3;
    logic [3:0] prev;
    do_reset();
    base = step_count;
    btn_mode = 1'b1;
    for (int k = 0; k < 30 && auto_active !== 1'b1; k++) @(negedge clk);
    t_entry = cyc;
    btn_mode = 1'b0;
    checks++;
    if (auto_active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL auto_entry: got %0b expected 1", auto_active);
    end
    prev = sel;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel !== prev) break;
    end
    t1 = cyc;
    checks++;
    if (sel !== 4'd1 || t1 - t_entry !== 8) begin
      errors++;
      $display("[TB] FAIL dwell_first: got sel %0d after %0d cycles expected sel 1 after 8", sel, t1 - t_entry);
    end
    prev = sel;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel !== prev) break;
    end
    t2 = cyc;
    checks++;
    if (sel !== 4'd2 || t2 - t1 !== 8) begin
      errors++;
      $display("[TB] FAIL dwell_second: got sel %0d after %0d cycles expected sel 2 after 8", sel, t2 - t1);
    end
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b1;
    idle(20);
    checks++;
    if (sel !== 4'd2) begin
      errors++;
      $display("[TB] FAIL hold_frozen: got %0d expected 2", sel);
    end
    hold = 1'b0;
    prev = sel;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel !== prev) break;
    end
    t3 = cyc;
    checks++;
    if (sel !== 4'd3 || t3 - t2 !== 28) begin
      errors++;
      $display("[TB] FAIL hold_resume: got sel %0d after %0d cycles expected sel 3 after 28", sel, t3 - t2);
    end
    checks++;
    if (step_count - base !== 3) begin
      errors++;
      $display("[TB] FAIL dwell_pulses: got %0d expected 3", step_count - base);
    end
    exp_sel = 3;
  endtask

  task automatic test_auto_both_and_reset();
    int base;
    hold = 1'b1;
    base = step_count;
    press(3, 20, 12);
    checks++;
    if (sel !== 4'(exp_sel) || step_count - base !== 0) begin
      errors++;
      $display("[TB] FAIL both_pressed: got sel %0d pulses %0d expected sel %0d pulses 0", sel, step_count - base, exp_sel);
    end
    hold = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 4'd0 || auto_active !== 1'b0 || step_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got sel %0d auto %0b step %0b expected 0 0 0", sel, auto_active, step_pulse);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    exp_sel = 0;
  endtask

  task automatic test_auto_exit();
    int base;
    base = step_count;
    hold = 1'b1;
    press(2, 12, 12);
    checks++;
    if (auto_active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL exit_enter: got %0b expected 1", auto_active);
    end
    press(2, 12, 12);
    checks++;
    if (auto_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exit_leave: got %0b expected 0", auto_active);
    end
    hold = 1'b0;
    idle(30);
    checks++;
    if (sel !== 4'(exp_sel) || step_count - base !== 0) begin
      errors++;
      $display("[TB] FAIL manual_idle: got sel %0d pulses %0d expected sel %0d pulses 0", sel, step_count - base, exp_sel);
    end
  endtask

`else

  task automatic test_auto_disabled();
    int base;
    base = step_count;
    hold = 1'b1;
    press(2, 12, 12);
    checks++;
    if (auto_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disabled_auto_after_press: got %0b expected 0", auto_active);
    end
    hold = 1'b0;
    idle(100);
    checks++;
    if (auto_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disabled_auto_idle: got %0b expected 0", auto_active);
    end
    checks++;
    if (sel !== 4'(exp_sel) || step_count - base !== 0) begin
      errors++;
      $display("[TB] FAIL disabled_sel: got sel %0d pulses %0d expected sel %0d pulses 0", sel, step_count - base, exp_sel);
    end
  endtask

`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_wrap();
    test_random_manual();
    test_reset_held();
`ifdef DISP_SCAN_AUTO_EN
    test_auto_dwell();
    test_auto_both_and_reset();
    test_auto_exit();
`else
    test_auto_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
